// File: rtl/line_rasterizer_if.sv
// line_rasterizer_if
//   Bundles the command side (splitter -> rasterizer) and the pixel write
//   side (rasterizer -> frame-buffer writer) of the line rasterizer.
//
//   Command side : enable, prim_sel, locations[37:0], color[15:0]
//   Status side  : busy, line_done
//   Pixel side   : pixel_write (valid), wr_ready (ready), pixel_addr[18:0],
//                  pixel_color[15:0]
//
//   Modports:
//     master - the environment (splitter + frame-buffer writer)
//     slave  - the rasterizer
//
//   Pixel handshake: a pixel transfers on a rising edge where pixel_write
//   and wr_ready are both 1. Once pixel_write is raised it stays raised,
//   with pixel_addr and pixel_color held stable, until that transfer edge;
//   wr_ready may change freely and does not depend on pixel_write.
interface line_rasterizer_if;
    logic        enable;
    logic        prim_sel;
    logic [37:0] locations;
    logic [15:0] color;
    logic        wr_ready;
    logic        pixel_write;
    logic [18:0] pixel_addr;
    logic [15:0] pixel_color;
    logic        busy;
    logic        line_done;

    modport master (
        output enable, prim_sel, locations, color, wr_ready,
        input  pixel_write, pixel_addr, pixel_color, busy, line_done
    );

    modport slave (
        input  enable, prim_sel, locations, color, wr_ready,
        output pixel_write, pixel_addr, pixel_color, busy, line_done
    );
endinterface

// File: rtl/line_rasterizer.sv
// line_rasterizer
//   Walks one line segment with integer Bresenham stepping and emits one
//   frame-buffer pixel write per visited in-range point. Pulses line_done
//   for one cycle when the segment is finished.
//
//   Ports:
//     clk        - system clock, rising edge
//     n_reset    - synchronous active-low reset
//     bus        - line_rasterizer_if.slave (command, status, pixel write)
//     dbg_state  - current FSM state (0 IDLE, 1 SETUP, 2 DRAW, 3 DONE)
//
//   Points outside H_RES x V_RES are skipped: they produce no write but
//   still take one DRAW cycle.
module line_rasterizer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic               clk,
    input  logic               n_reset,
    line_rasterizer_if.slave   bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [9:0]  V_LIM = 10'(V_RES);

    state_e              state_q, state_d;
    logic        [9:0]   cx_q, cx_d;       // current x
    logic        [8:0]   cy_q, cy_d;       // current y
    logic        [9:0]   x1_q, x1_d;       // end x
    logic        [8:0]   y1_q, y1_d;       // end y
    logic        [15:0]  color_q, color_d;
    logic        [10:0]  dx_q, dx_d;       // |x1-x0|, always non-negative
    logic signed [10:0]  dy_q, dy_d;       // -|y1-y0|, always non-positive
    logic                sx_neg_q, sx_neg_d;  // x steps by -1 when set
    logic                sy_neg_q, sy_neg_d;  // y steps by -1 when set
    logic signed [12:0]  err_q, err_d;

    logic                in_range;
    logic                at_end;
    logic                advance;
    logic signed [13:0]  e2;
    logic signed [13:0]  dx14;
    logic signed [13:0]  dy14;
    logic                step_x;
    logic                step_y;
    logic        [8:0]   ady;

    assign in_range = ({1'b0, cx_q} < H_LIM) && ({1'b0, cy_q} < V_LIM);
    assign at_end   = (cx_q == x1_q) && (cy_q == y1_q);
    // A clipped point never waits for the writer.
    assign advance  = in_range ? bus.wr_ready : 1'b1;

    // Both step decisions look at the pre-step error term.
    assign e2     = {err_q, 1'b0};
    assign dx14   = $signed({3'b000, dx_q});
    assign dy14   = $signed({{3{dy_q[10]}}, dy_q});
    assign step_x = (e2 >= dy14);
    assign step_y = (e2 <= dx14);

    assign ady = (y1_q >= cy_q) ? (y1_q - cy_q) : (cy_q - y1_q);

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        color_d  = color_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.enable && !bus.prim_sel) begin
                    state_d = SETUP;
                    // The start point is loaded straight into the walker.
                    cx_d    = bus.locations[37:28];
                    cy_d    = bus.locations[27:19];
                    x1_d    = bus.locations[18:9];
                    y1_d    = bus.locations[8:0];
                    color_d = bus.color;
                end
            end

            SETUP: begin
                sx_neg_d = (x1_q < cx_q);
                sy_neg_d = (y1_q < cy_q);
                dx_d     = (x1_q >= cx_q) ? ({1'b0, x1_q} - {1'b0, cx_q})
                                          : ({1'b0, cx_q} - {1'b0, x1_q});
                dy_d     = $signed(11'd0 - {2'b00, ady});
                err_d    = $signed({2'b00, dx_d}) + $signed({{2{dy_d[10]}}, dy_d});
                state_d  = DRAW;
            end

            DRAW: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        err_d = err_q
                              + (step_x ? $signed({{2{dy_q[10]}}, dy_q}) : 13'sd0)
                              + (step_y ? $signed({2'b00, dx_q})         : 13'sd0);
                        if (step_x) begin
                            cx_d = sx_neg_q ? (cx_q - 10'd1) : (cx_q + 10'd1);
                        end
                        if (step_y) begin
                            cy_d = sy_neg_q ? (cy_q - 9'd1) : (cy_q + 9'd1);
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            color_q  <= color_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
        end
    end

    // Linear address y*640 + x as two shifts plus x.
    assign bus.pixel_addr  = {1'b0, cy_q, 9'b0} + {3'b000, cy_q, 7'b0} + {9'b0, cx_q};
    assign bus.pixel_color = color_q;
    assign bus.pixel_write = (state_q == DRAW) && in_range;
    assign bus.busy        = (state_q != IDLE);
    assign bus.line_done   = (state_q == DONE);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_line_rasterizer.sv
module tb_line_rasterizer;

  localparam int H = 640;
  localparam int V = 480;

  logic       clk;
  logic       n_reset;
  logic [1:0] dbg_state;

  line_rasterizer_if bus_if ();

  line_rasterizer #(.H_RES(H), .V_RES(V)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Visits the Bresenham points from A to B and queues the address of each
  // on-screen point; returns the number of points visited.
  function automatic int model_fill(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y, p;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    p = 0;
    forever begin
      if (x < H && y < V) exp_q.push_back(19'(y * 640 + x));
      p++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return p;
  endfunction

  function automatic logic pick_ready(input int mode, input int k);
    logic [3:0] pat;
    pat = 4'b1001;  // 1,0,0,1 repeating
    case (mode)
      0:       return 1'b1;
      1:       return pat[k[1:0]];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // ---------------- driver + scoreboard for one line ----------------
  // exp_q must be loaded before the call. exp_lat > 0 checks the
  // enable-edge to line_done latency; check_tail checks that line_done
  // follows the last accepted write directly.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input logic [15:0] col, input int rmode, input bit noise,
                          input int exp_lat, input bit check_tail, input string name);
    int k, last_acc;
    bit done, stalled;
    logic [18:0] held_addr;
    logic [15:0] held_col;
    k = 0; last_acc = -10; done = 0; stalled = 0;
    held_addr = '0; held_col = '0;
    @(posedge clk); #1;
    bus_if.locations = {x0[9:0], y0[8:0], x1[9:0], y1[8:0]};
    bus_if.color     = col;
    bus_if.prim_sel  = 1'b0;
    bus_if.enable    = 1'b1;
    bus_if.wr_ready  = pick_ready(rmode, 0);
    @(posedge clk); #1;
    bus_if.enable    = 1'b0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
      total++;
      if (bus_if.busy !== 1'b1) begin
        bad++; $display("FAIL %s busy: got %b expected 1 at cycle %0d", name, bus_if.busy, k);
      end
      if (k == 1) begin
        total++;
        if (bus_if.pixel_write !== 1'b0) begin
          bad++; $display("FAIL %s setup_write: got %b expected 0", name, bus_if.pixel_write);
        end
      end
      if (stalled) begin
        total++;
        if (bus_if.pixel_write !== 1'b1 || bus_if.pixel_addr !== held_addr || bus_if.pixel_color !== held_col) begin
          bad++;
          $display("FAIL %s stall_hold: got w=%b a=%0d c=%h expected w=1 a=%0d c=%h",
                   name, bus_if.pixel_write, bus_if.pixel_addr, bus_if.pixel_color, held_addr, held_col);
        end
      end
      if (bus_if.line_done === 1'b1) begin
        done = 1;
        bus_if.enable = 1'b0;
        total++;
        if (bus_if.pixel_write !== 1'b0 || exp_q.size() != 0) begin
          bad++;
          $display("FAIL %s done_state: got write=%b missing=%0d expected write=0 missing=0",
                   name, bus_if.pixel_write, exp_q.size());
        end
        if (exp_lat > 0) begin
          total++;
          if (k != exp_lat) begin
            bad++; $display("FAIL %s latency: got %0d expected %0d", name, k, exp_lat);
          end
        end
        if (check_tail) begin
          total++;
          if (k != last_acc + 1) begin
            bad++; $display("FAIL %s done_after_last: got cycle %0d expected %0d", name, k, last_acc + 1);
          end
        end
      end else if (bus_if.pixel_write === 1'b1) begin
        if (bus_if.wr_ready) begin
          stalled  = 0;
          last_acc = k;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL %s extra_write: got addr %0d expected no write", name, bus_if.pixel_addr);
          end else begin
            logic [18:0] ea;
            ea = exp_q.pop_front();
            if (bus_if.pixel_addr !== ea || bus_if.pixel_color !== col) begin
              bad++;
              $display("FAIL %s pixel: got a=%0d c=%h expected a=%0d c=%h",
                       name, bus_if.pixel_addr, bus_if.pixel_color, ea, col);
            end
          end
        end else begin
          stalled   = 1;
          held_addr = bus_if.pixel_addr;
          held_col  = bus_if.pixel_color;
        end
      end else begin
        stalled = 0;
      end
      if (!done) begin
        @(posedge clk); #1;
        bus_if.wr_ready = pick_ready(rmode, k);
        if (noise) bus_if.enable = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      bad++; total++;
      $display("FAIL %s timeout: got no line_done after %0d cycles expected line_done", name, k);
      bus_if.enable = 1'b0;
    end
    // After the DONE cycle the block must be idle and must not restart.
    @(posedge clk); #1;
    bus_if.wr_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus_if.busy !== 1'b0 || bus_if.line_done !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL %s post_done: got busy=%b done=%b st=%0d expected 0 0 0",
               name, bus_if.busy, bus_if.line_done, dbg_state);
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_reset = 1'b0;
    bus_if.enable = 1'b0; bus_if.prim_sel = 1'b0; bus_if.wr_ready = 1'b1;
    bus_if.locations = '0; bus_if.color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus_if.pixel_write !== 1'b0 || bus_if.line_done !== 1'b0 || bus_if.busy !== 1'b0 ||
        bus_if.pixel_addr !== 19'd0 || bus_if.pixel_color !== 16'd0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got w=%b d=%b b=%b a=%0d c=%h st=%0d expected all 0",
               bus_if.pixel_write, bus_if.line_done, bus_if.busy, bus_if.pixel_addr,
               bus_if.pixel_color, dbg_state);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
  endtask

  task automatic test_directed();
    exp_q = '{19'd0, 19'd1, 19'd2, 19'd3};
    run_line(0, 0, 3, 0, 16'hF81F, 0, 0, 6, 1, "horizontal");
    exp_q = '{19'd1285, 19'd1925, 19'd2565};
    run_line(5, 2, 5, 4, 16'h07E0, 0, 0, 5, 1, "vertical");
    exp_q = '{19'd1923, 19'd1282, 19'd641, 19'd0};
    run_line(3, 3, 0, 0, 16'h001F, 0, 0, 6, 1, "reverse_diag");
    exp_q = '{19'd0, 19'd640, 19'd1281, 19'd1921};
    run_line(0, 0, 1, 3, 16'h1234, 0, 0, 6, 1, "steep");
  endtask

  task automatic test_backpressure();
    exp_q = '{19'd0, 19'd1, 19'd2, 19'd3};
    run_line(0, 0, 3, 0, 16'hABCD, 1, 0, 0, 1, "backpressure");
  endtask

  task automatic test_clip_single();
    exp_q = '{19'd638, 19'd639};
    run_line(638, 0, 641, 0, 16'h5555, 0, 0, 6, 0, "clip");
    exp_q = '{19'd647};
    run_line(7, 1, 7, 1, 16'hAAAA, 0, 0, 3, 1, "single");
  endtask

  task automatic test_arc_ignore();
    @(posedge clk); #1;
    bus_if.locations = {10'd1, 9'd1, 10'd5, 9'd5};
    bus_if.prim_sel  = 1'b1;
    bus_if.enable    = 1'b1;
    @(posedge clk); #1;
    bus_if.enable   = 1'b0;
    bus_if.prim_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus_if.busy !== 1'b0 || bus_if.pixel_write !== 1'b0 || bus_if.line_done !== 1'b0 || dbg_state !== 2'd0) begin
        bad++;
        $display("FAIL arc_ignore: got b=%b w=%b d=%b st=%0d expected 0 0 0 0",
                 bus_if.busy, bus_if.pixel_write, bus_if.line_done, dbg_state);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    int acc, cyc;
    acc = 0; cyc = 0;
    @(posedge clk); #1;
    bus_if.locations = {10'd0, 9'd0, 10'd9, 9'd0};
    bus_if.color     = 16'hBEEF;
    bus_if.enable    = 1'b1;
    bus_if.wr_ready  = 1'b1;
    @(posedge clk); #1;
    bus_if.enable = 1'b0;
    while (acc < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus_if.pixel_write === 1'b1 && bus_if.wr_ready) acc++;
    end
    total++;
    if (acc != 3) begin
      bad++; $display("FAIL mid_reset_progress: got %0d writes expected 3", acc);
    end
    @(posedge clk); #1;   // third pixel consumed at this edge
    n_reset = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus_if.pixel_write !== 1'b0 || bus_if.line_done !== 1'b0 || bus_if.busy !== 1'b0 ||
        bus_if.pixel_addr !== 19'd0 || bus_if.pixel_color !== 16'd0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset_state: got w=%b d=%b b=%b a=%0d c=%h st=%0d expected all 0",
               bus_if.pixel_write, bus_if.line_done, bus_if.busy, bus_if.pixel_addr,
               bus_if.pixel_color, dbg_state);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus_if.line_done !== 1'b0 || bus_if.busy !== 1'b0) begin
        bad++; $display("FAIL mid_reset_quiet: got d=%b b=%b expected 0 0", bus_if.line_done, bus_if.busy);
      end
    end
    void'(model_fill(0, 0, 9, 0));
    run_line(0, 0, 9, 0, 16'hBEEF, 0, 0, 12, 1, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int x0, y0, x1, y1, p, rm;
      x0 = int'($urandom_range(0, 720));
      y0 = int'($urandom_range(0, 511));
      x1 = x0 + int'($urandom_range(0, 80)) - 40;
      y1 = y0 + int'($urandom_range(0, 80)) - 40;
      if (x1 < 0) x1 = 0;
      if (x1 > 1023) x1 = 1023;
      if (y1 < 0) y1 = 0;
      if (y1 > 511) y1 = 511;
      rm = int'($urandom_range(0, 2));
      p = model_fill(x0, y0, x1, y1);
      run_line(x0, y0, x1, y1, 16'($urandom), rm, 1, (rm == 0) ? p + 2 : 0, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      int p;
      p = model_fill(10 * n, n, 10 * n + 5, n + 2);
      run_line(10 * n, n, 10 * n + 5, n + 2, 16'(n + 1), 0, 0, p + 2, 1, "back_to_back");
    end
  endtask

  initial begin
    bus_if.enable = 1'b0;
    bus_if.prim_sel = 1'b0;
    bus_if.wr_ready = 1'b1;
    bus_if.locations = '0;
    bus_if.color = '0;
    n_reset = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_clip_single();
    test_arc_ignore();
    test_reset_mid_draw();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_rasterizer.md
# line_rasterizer

Primitive engine at the downstream end of the shape-detection/splitter stage. It accepts one line segment at a time as a packed 38-bit endpoint pair plus 16-bit color. It walks the segment with integer Bresenham stepping and emits one frame-buffer pixel write per accepted cycle. When the segment is finished it pulses `line_done`, which tells the splitter to issue the next line (triangle edge) or the next shape.

## Interface
Parameters:
- `H_RES`, 640, horizontal resolution; x ≥ `H_RES` is clipped.
- `V_RES`, 480, vertical resolution; y ≥ `V_RES` is clipped.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `n_reset`  in  1  reset; one clock, reset synchronous active-low.
- `enable`  in  1  start strobe from splitter; sampled only in IDLE.
- `prim_sel`  in  1  0 = line primitive (handled here), 1 = arc (ignored here).
- `locations`  in  38  segment endpoints:
  - [37:19] = start point A, [18:0] = end point B.
  - Each 19-bit point is {x[9:0], y[8:0]}.
- `color`  in  16  RGB565 color, captured with the locations.
- `wr_ready`  in  1  frame-buffer writer can accept a pixel this cycle.
- `pixel_write`  out  1  pixel valid.
- `pixel_addr`  out  19  linear address y*640 + x.
- `pixel_color`  out  16  captured color.
- `busy`  out  1  high in every state except IDLE.
- `line_done`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, SETUP, DRAW, DONE.
- **IDLE → SETUP:** on `enable`=1 and `prim_sel`=0.
  - At that edge, capture x0,y0,x1,y1 and `color`.
  - `enable` with `prim_sel`=1 is ignored; stay IDLE, no `line_done`.
- **SETUP (1 cycle):**
  - dx = |x1−x0| (11-bit), dy = −|y1−y0| (11-bit signed).
  - sx/sy = +1 if endpoint ≥ start, else −1.
  - err = dx + dy (13-bit signed).
  - Load current point (cx,cy) = (x0,y0). Go to DRAW.
- **DRAW, per cycle:**
  - Current point in range (cx < `H_RES` and cy < `V_RES`): `pixel_write`=1. The step happens only when `wr_ready`=1.
  - Current point out of range: `pixel_write`=0 and step unconditionally (clipped pixel costs one cycle).
  - Step rule: if (cx,cy)==(x1,y1), go to DONE. Otherwise compute e2 = 2·err (14-bit signed), then:
    - if e2 ≥ dy: err += dy, cx += sx.
    - if e2 ≤ dx: err += dx, cy += sy.
    - Both updates use the pre-step err.
- **Pixel count:** max(|dx|,|dy|)+1 points visited, endpoints inclusive. A = B gives exactly one pixel.
- **DONE (1 cycle):** `line_done`=1, then IDLE.
- **Address:** `pixel_addr` = (cy<<9) + (cy<<7) + cx, computed combinationally from cx,cy in 19 bits; it does not wrap for in-range points.
- **`enable` while busy:** ignored; no queueing.
- **Reset:** `n_reset`=0 at any edge, including mid-DRAW:
  - State → IDLE.
  - All internal registers cleared.
  - `pixel_write`, `line_done`, `busy` = 0; `pixel_addr` = 0; `pixel_color` = 0.
  - The partially drawn line is abandoned; no `line_done` for it.

## Timing
- `enable` at edge N:
  - SETUP during cycle N+1.
  - First `pixel_write` valid during cycle N+2.
- With `wr_ready` held high: one pixel per cycle.
  - `line_done` is high in the cycle after the last point's accepted write.
  - Total latency, enable edge to `line_done` high = P+2 cycles, where P = points.
- **Handshake:**
  - Once `pixel_write` asserts, `pixel_addr` and `pixel_color` hold stable until the cycle where `wr_ready`=1.
  - `pixel_write` is never withdrawn while `wr_ready`=0.
- `busy` rises at edge N and falls at the edge leaving DONE.
- Earliest next accepted `enable`: the IDLE cycle immediately after DONE.

## Test plan
- **Horizontal line,** `wr_ready`=1:
  - Stimulus: A=(0,0), B=(3,0).
  - Required: addrs 0,1,2,3 on 4 consecutive cycles; color echoed; `line_done` one cycle later; total 6 cycles enable→done.
- **Vertical + reverse diagonal:**
  - (5,2)→(5,4) → 1285, 1925, 2565.
  - (3,3)→(0,0) → 1923, 1282, 641, 0.
- **Steep line:**
  - (0,0)→(1,3) → exactly 0, 640, 1281, 1921.
- **Backpressure:**
  - Horizontal test with `wr_ready` toggled 1,0,0,1,...
  - Required: addr/color held stable during stalls; no pixel skipped or duplicated; `line_done` after 4th accepted write.
- **Clip, single point, arc ignore:**
  - (638,0)→(641,0) → writes 638, 639 only; 4 DRAW cycles; `line_done` pulses.
  - A=B=(7,1) → single write 647.
  - `enable` with `prim_sel`=1 → no activity, `busy`=0.
- **Reset mid-draw:**
  - Stimulus: `n_reset`=0 during DRAW of (0,0)→(9,0) after 3 pixels.
  - Required: next cycle all outputs 0, state IDLE, no `line_done`.
  - A fresh `enable` afterwards draws the full line correctly from addr 0.
